// File: rtl/mux2_rr_arbiter.sv
// Round-robin controller for a shared 2:1 data mux with a
// one-entry registered output stage and a per-owner hold limit.
module mux2_rr_arbiter #(
   parameter int DW       = 2,
   parameter int MAX_HOLD = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_a,
   input  logic [DW-1:0] data_a,
   output logic          gnt_a,
   input  logic          req_b,
   input  logic [DW-1:0] data_b,
   output logic          gnt_b,
   output logic          sel,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HLAST = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_A,
      GRANT_B
   } state_t;

   state_t        state;
   logic          last_a;
   logic [HW-1:0] hold_cnt;

   logic can_accept;
   logic xfer;
   logic own_req;
   logic oth_req;
   logic done;

   assign can_accept = !out_valid || out_ready;
   assign gnt_a = (state == GRANT_A) && req_a && can_accept;
   assign gnt_b = (state == GRANT_B) && req_b && can_accept;

   // done: owner has released the channel or used up its turn
   always_comb begin
      xfer    = gnt_a || gnt_b;
      own_req = (state == GRANT_A) ? req_a : req_b;
      oth_req = (state == GRANT_A) ? req_b : req_a;
      done    = !own_req || (xfer && (hold_cnt == HLAST));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel       <= 1'b0;
         last_a    <= 1'b0;
         hold_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (gnt_a) begin
            out_data  <= data_a;
            out_valid <= 1'b1;
         end else if (gnt_b) begin
            out_data  <= data_b;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (req_a && (!req_b || !last_a)) begin
                  state    <= GRANT_A;
                  sel      <= 1'b1;
                  hold_cnt <= '0;
               end else if (req_b) begin
                  state    <= GRANT_B;
                  sel      <= 1'b0;
                  hold_cnt <= '0;
               end
            end
            GRANT_A, GRANT_B: begin
               if (done) begin
                  last_a <= (state == GRANT_A);
                  if (oth_req) begin
                     state    <= (state == GRANT_A) ? GRANT_B : GRANT_A;
                     sel      <= (state == GRANT_B);
                     hold_cnt <= '0;
                  end else if (own_req) begin
                     hold_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end else if (xfer) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus random traffic
// on a MAX_HOLD=4 and a MAX_HOLD=1 instance, checked by a channel model.
module tb_mux2_rr_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       ra[2], rb[2], rdy[2];
   logic [1:0] da[2], db[2];
   logic       ga[2], gb[2], sl[2], ov[2];
   logic [1:0] od[2];

   int errs = 0;
   int checks = 0;

   mux2_rr_arbiter #(.DW(2), .MAX_HOLD(4)) dut (
      .clk(clk), .rst(rst),
      .req_a(ra[0]), .data_a(da[0]), .gnt_a(ga[0]),
      .req_b(rb[0]), .data_b(db[0]), .gnt_b(gb[0]),
      .sel(sl[0]), .out_valid(ov[0]), .out_data(od[0]),
      .out_ready(rdy[0])
   );

   mux2_rr_arbiter #(.DW(2), .MAX_HOLD(1)) dut1 (
      .clk(clk), .rst(rst),
      .req_a(ra[1]), .data_a(da[1]), .gnt_a(ga[1]),
      .req_b(rb[1]), .data_b(db[1]), .gnt_b(gb[1]),
      .sel(sl[1]), .out_valid(ov[1]), .out_data(od[1]),
      .out_ready(rdy[1])
   );

   // channel model: owner 0=none 1=A 2=B, turns used, last owner served
   int         m_own[2], m_used[2], m_last[2], mh[2];
   logic       m_sel[2], m_ov[2], m_ga[2], m_gb[2];
   logic [1:0] m_od[2];
   logic [1:0] exp2[9];

   task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_own[i] = 0; m_used[i] = 0; m_last[i] = 2;
         m_sel[i] = 1'b0; m_ov[i] = 1'b0; m_od[i] = 2'd0;
         m_ga[i] = 1'b0; m_gb[i] = 1'b0;
      end
   endtask

   task automatic model_check(int i);
      logic ca;
      ca = !m_ov[i] || rdy[i];
      chk($sformatf("gnt_a%0d", i), ga[i], (m_own[i] == 1) && ra[i] && ca);
      chk($sformatf("gnt_b%0d", i), gb[i], (m_own[i] == 2) && rb[i] && ca);
      chk($sformatf("sel%0d", i), sl[i], m_sel[i]);
      chk($sformatf("out_valid%0d", i), ov[i], m_ov[i]);
      chk($sformatf("out_data%0d", i), od[i], m_od[i]);
   endtask

   task automatic model_step(int i);
      logic ca, g_a, g_b, me, oth;
      int u;
      ca  = !m_ov[i] || rdy[i];
      g_a = (m_own[i] == 1) && ra[i] && ca;
      g_b = (m_own[i] == 2) && rb[i] && ca;
      m_ga[i] = g_a;
      m_gb[i] = g_b;
      if (g_a) begin
         m_od[i] = da[i]; m_ov[i] = 1'b1;
      end else if (g_b) begin
         m_od[i] = db[i]; m_ov[i] = 1'b1;
      end else if (rdy[i]) begin
         m_ov[i] = 1'b0;
      end
      if (m_own[i] == 0) begin
         if (ra[i] && rb[i]) m_own[i] = (m_last[i] == 1) ? 2 : 1;
         else if (ra[i]) m_own[i] = 1;
         else if (rb[i]) m_own[i] = 2;
         m_used[i] = 0;
      end else begin
         me  = (m_own[i] == 1) ? ra[i] : rb[i];
         oth = (m_own[i] == 1) ? rb[i] : ra[i];
         u = m_used[i] + ((g_a || g_b) ? 1 : 0);
         if (!me || u == mh[i]) begin
            m_last[i] = m_own[i];
            m_used[i] = 0;
            if (oth) m_own[i] = 3 - m_own[i];
            else if (!me) m_own[i] = 0;
         end else begin
            m_used[i] = u;
         end
      end
      if (m_own[i] == 1) m_sel[i] = 1'b1;
      else if (m_own[i] == 2) m_sel[i] = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      model_check(0);
      model_check(1);
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 2; i++) begin
         ra[i] = 1'b0; rb[i] = 1'b0; rdy[i] = 1'b1;
         da[i] = 2'd0; db[i] = 2'd0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      mh[0] = 4;
      mh[1] = 1;
      exp2 = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
      rst = 1'b1;
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_valid", ov[0], 2'd0);
      chk("rst_data", od[0], 2'd0);
      chk("rst_sel", sl[0], 2'd0);
      ra[0] = 1'b1;
      #1;
      chk("rst_gnt_a", ga[0], 2'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // A alone, word 2
      da[0] = 2'd2;
      tick();
      chk("t1_gnt_a", ga[0], 2'd1);
      chk("t1_sel", sl[0], 2'd1);
      chk("t1_nvalid", ov[0], 2'd0);
      tick();
      chk("t1_valid", ov[0], 2'd1);
      chk("t1_data", od[0], 2'd2);
      ra[0] = 1'b0;
      tick();
      chk("t1_drain", ov[0], 2'd0);

      // both requesting continuously on both instances
      do_reset();
      for (int i = 0; i < 2; i++) begin
         ra[i] = 1'b1; rb[i] = 1'b1; da[i] = 2'd1; db[i] = 2'd2;
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) begin
            chk("t2_idle", ov[0], 2'd0);
         end else begin
            chk("t2_seq", od[0], exp2[k-2]);
            chk("t2_nogap", ov[0], 2'd1);
            chk("t3_alt", od[1], (k % 2 == 0) ? 2'd1 : 2'd2);
         end
      end
      ra[0] = 1'b0; rb[0] = 1'b0;
      ra[1] = 1'b0; rb[1] = 1'b0;
      tick();
      tick();
      ra[1] = 1'b1;
      tick();
      tick();
      ra[1] = 1'b0;
      tick();
      ra[1] = 1'b1; rb[1] = 1'b1;
      tick();
      chk("t3_bfirst_sel", sl[1], 2'd0);
      chk("t3_bfirst_gnt", gb[1], 2'd1);

      // B alone then sink stalls
      do_reset();
      rb[0] = 1'b1; db[0] = 2'd3;
      tick();
      tick();
      rdy[0] = 1'b0;
      #1;
      chk("t4_stall_gnt", gb[0], 2'd0);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("t4_hold_valid", ov[0], 2'd1);
         chk("t4_hold_data", od[0], 2'd3);
         chk("t4_hold_gnt", gb[0], 2'd0);
      end
      rdy[0] = 1'b1;
      #1;
      chk("t4_resume_gnt", gb[0], 2'd1);
      tick();
      chk("t4_resume_valid", ov[0], 2'd1);
      chk("t4_resume_data", od[0], 2'd3);

      // asynchronous reset mid-burst
      do_reset();
      ra[0] = 1'b1; da[0] = 2'd2;
      tick();
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("t5_valid", ov[0], 2'd0);
      chk("t5_data", od[0], 2'd0);
      chk("t5_sel", sl[0], 2'd0);
      chk("t5_gnt_a", ga[0], 2'd0);
      model_reset();
      rb[0] = 1'b1; db[0] = 2'd1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("t5_afirst_sel", sl[0], 2'd1);
      chk("t5_afirst_gnt", ga[0], 2'd1);

      // A drops after two words as B rises
      do_reset();
      ra[0] = 1'b1; da[0] = 2'd1;
      tick();
      tick();
      tick();
      ra[0] = 1'b0; rb[0] = 1'b1; db[0] = 2'd2;
      #1;
      chk("t6_sel_a", sl[0], 2'd1);
      chk("t6_no_gnt_b", gb[0], 2'd0);
      tick();
      chk("t6_sel_b", sl[0], 2'd0);
      chk("t6_gnt_b", gb[0], 2'd1);
      tick();
      chk("t6_data", od[0], 2'd2);

      // random traffic, requests held until granted
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!ra[i] || m_ga[i]) begin
               ra[i] = ($urandom_range(0, 2) != 0);
               da[i] = 2'($urandom);
            end
            if (!rb[i] || m_gb[i]) begin
               rb[i] = ($urandom_range(0, 2) != 0);
               db[i] = 2'($urandom);
            end
            rdy[i] = ($urandom_range(0, 3) != 0);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
